// File: rtl/game_pkg.sv
// Shared types for the adventure-game core and its scripted player.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'b00,
    DIR_S = 2'b01,
    DIR_E = 2'b10,
    DIR_W = 2'b11
  } dir_code_t;

  typedef enum logic [1:0] {
    RES_NONE      = 2'b00,
    RES_WON       = 2'b01,
    RES_DEAD      = 2'b10,
    RES_EXHAUSTED = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_DONE
  } player_state_t;

endpackage

// File: rtl/dir_decode.sv
// Direction code to one-hot {n,s,e,w}; shared with the game bench.
module dir_decode
  import game_pkg::*;
(
  input  dir_code_t  dir_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    onehot_o = 4'b0000;
    unique case (dir_i)
      DIR_N:   onehot_o = 4'b1000;
      DIR_S:   onehot_o = 4'b0100;
      DIR_E:   onehot_o = 4'b0010;
      DIR_W:   onehot_o = 4'b0001;
      default: onehot_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/move_player.sv
// Scripted initiator: stores a move list, replays it as n/s/e/w
// pulses and stops on the game's first dead/win/exhausted event.
module move_player
  import game_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [1:0]                 load_dir,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       d,
  input  logic                       win,
  output logic                       n,
  output logic                       s,
  output logic                       e,
  output logic                       w,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 result,
  output logic [$clog2(DEPTH+1)-1:0] moves_made,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  player_state_t state_q, state_d;
  dir_code_t     script_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] mm_q, mm_d;
  logic [GW-1:0] gap_q, gap_d;
  result_t       res_q, res_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    dir_q, dir_d;
  logic          wr_en;
  logic          idle_like;
  dir_code_t     nxt_code;
  logic [3:0]    nxt_oh;
  result_t       term_res;

  // Pulse registers are loaded on entry to DRIVE, so a pulse
  // coincides exactly with the DRIVE cycle.
  assign nxt_code = (state_q == ST_GAP) ?
                    script_q[idx_q[AW-1:0]] : script_q[0];

  dir_decode u_dec (
    .dir_i    (nxt_code),
    .onehot_o (nxt_oh)
  );

  assign term_res = d ? RES_DEAD : RES_WON;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    mm_d      = mm_q;
    gap_d     = gap_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    dir_d     = 4'b0000;
    wr_en     = 1'b0;
    idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);

    if (idle_like) begin
      if (clear) begin
        count_d = '0;
        ovf_d   = 1'b0;
      end else if (load_en) begin
        if (count_q == CW'(DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d = '0;
          mm_d  = '0;
          if (count_q != '0 && !clear) begin
            state_d = ST_DRIVE;
            res_d   = RES_NONE;
            dir_d   = nxt_oh;
          end else begin
            state_d = ST_DONE;
            res_d   = RES_EXHAUSTED;
          end
        end
      end
      ST_DRIVE: begin
        idx_d = idx_q + CW'(1);
        mm_d  = mm_q + CW'(1);
        gap_d = '0;
        if (d || win) begin
          state_d = ST_DONE;
          res_d   = term_res;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (d || win) begin
          state_d = ST_DONE;
          res_d   = term_res;
        end else if (gap_q == GW'(GAP - 1)) begin
          if (idx_q == count_q) begin
            state_d = ST_DONE;
            res_d   = RES_EXHAUSTED;
          end else begin
            state_d = ST_DRIVE;
            dir_d   = nxt_oh;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      mm_q    <= '0;
      gap_q   <= '0;
      res_q   <= RES_NONE;
      ovf_q   <= 1'b0;
      dir_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      gap_q   <= gap_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      dir_q   <= dir_d;
    end
  end

  // Script contents need no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      script_q[count_q[AW-1:0]] <= dir_code_t'(load_dir);
    end
  end

  assign {n, s, e, w} = dir_q;
  assign busy         = (state_q == ST_DRIVE) || (state_q == ST_GAP);
  assign done         = (state_q == ST_DONE);
  assign result       = res_q;
  assign moves_made   = mm_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_move_player.sv
// Randomized self-checking bench for move_player against a
// timeline model derived from script length and event cycle.
module tb_move_player;

  localparam int DEPTH = 16;
  localparam int GAP   = 2;
  localparam int PER   = GAP + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [1:0]    load_dir;
  logic          clear;
  logic          start;
  logic          d;
  logic          win;
  logic          n, s, e, w;
  logic          busy, done;
  logic [1:0]    result;
  logic [CW-1:0] moves_made;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [1:0] q_m [$];
  bit         ovf_m;

  move_player #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_dir   (load_dir),
    .clear      (clear),
    .start      (start),
    .d          (d),
    .win        (win),
    .n          (n),
    .s          (s),
    .e          (e),
    .w          (w),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .moves_made (moves_made),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] v;
    v = 4'b1000 >> c;
    return v;
  endfunction

  task automatic load(input logic [1:0] dir);
    load_en  = 1'b1;
    load_dir = dir;
    @(negedge clk);
    load_en  = 1'b0;
    if (q_m.size() == DEPTH) ovf_m = 1'b1;
    else q_m.push_back(dir);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    q_m.delete();
    ovf_m = 1'b0;
  endtask

  // t: cycle after start in which the event is presented (<1: none
  // during the run); td/tw: which event lines go high that cycle.
  task automatic run(input int t, input bit td, input bit tw);
    int nm, last, endc, expm;
    logic [1:0] expr;
    logic [3:0] exp_oh;
    nm   = q_m.size();
    last = nm * PER;
    if (nm == 0) begin
      endc = 1; expm = 0; expr = 2'b11;
    end else if (t >= 1 && t <= last) begin
      endc = t + 1; expm = (t - 1) / PER + 1;
      expr = td ? 2'b10 : 2'b01;
    end else begin
      endc = last + 1; expm = nm; expr = 2'b11;
    end
    start = 1'b1;
    d     = (t == 0) && td;
    win   = (t == 0) && tw;
    for (int c = 1; c <= endc; c++) begin
      @(negedge clk);
      start   = 1'b0;
      load_en = 1'b0;
      clear   = 1'b0;
      exp_oh  = 4'b0000;
      if (c < endc && (c - 1) % PER == 0)
        exp_oh = oh(q_m[(c - 1) / PER]);
      chk("dir", {n, s, e, w}, exp_oh);
      chk("busy", busy, c < endc);
      chk("done", done, c == endc);
      if (c == endc) begin
        chk("result", result, expr);
        chk("moves", moves_made, expm);
      end
      d   = (c == t) && td;
      win = (c == t) && tw;
      if (c == 2 && c < endc) begin
        load_en  = 1'b1;
        load_dir = 2'($urandom);
        clear    = 1'($urandom);
        start    = 1'b1;
      end
    end
    d   = 1'b0;
    win = 1'b0;
  endtask

  initial begin
    int nm, t, k;
    reset = 1'b0; load_en = 1'b0; load_dir = 2'b00; clear = 1'b0;
    start = 1'b0; d = 1'b0; win = 1'b0; ovf_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dir", {n, s, e, w}, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_res", result, 2'b00);
    chk("rst_moves", moves_made, '0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    load(2'b10); load(2'b01); load(2'b11); load(2'b10);
    run(-1, 1'b0, 1'b0);
    run(8, 1'b0, 1'b1);
    run(5, 1'b1, 1'b1);
    run(-1, 1'b0, 1'b0);
    run(0, 1'b1, 1'b0);

    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) load(2'($urandom));
    chk("ovf_set", overflow, ovf_m);
    run(-1, 1'b0, 1'b0);
    do_clear();
    chk("ovf_clr", overflow, 1'b0);
    run(-1, 1'b0, 1'b0);

    load(2'b00); load(2'b01);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_dir", {n, s, e, w}, 4'b0000);
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_res", result, 2'b00);
    reset = 1'b1;
    q_m.delete();
    ovf_m = 1'b0;
    run(-1, 1'b0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      do_clear();
      nm = $urandom_range(0, DEPTH + 2);
      for (int i = 0; i < nm; i++) load(2'($urandom));
      chk("ovf_rnd", overflow, ovf_m);
      t = $urandom_range(0, q_m.size() * PER + 2);
      if ($urandom_range(0, 3) == 0) t = -1;
      k = $urandom_range(1, 3);
      run(t, k[0], k[1]);
      if ($urandom_range(0, 1) == 1) run(-1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/move_player.md
Name: move_player

Overview:
- Scripted initiator for the adventure-game core.
- Stores a short list of moves through a load port, then replays them as one-cycle, one-hot n/s/e/w pulses. This is the same direction interface the game consumes.
- Samples the game's d/win outputs and stops on the first terminal event. Reports the outcome and the number of moves issued.
- Sits in front of the game on the board top and in regression benches, replacing hand-written stimulus.

Parameters:
- DEPTH, 16: maximum number of moves in the script (>=2).
- GAP, 2: idle cycles after each move pulse before the next move or the exhaustion check (>=1). Covers the game's registered d/win latency.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- load_en  input  1  append load_dir to script; accepted only in IDLE or DONE
- load_dir  input  2  move code: 00=N, 01=S, 10=E, 11=W
- clear  input  1  empty the script; accepted only in IDLE or DONE
- start  input  1  begin replay from move 0
- d  input  1  game "dead" output
- win  input  1  game "win" output
- n  output  1  north pulse
- s  output  1  south pulse
- e  output  1  east pulse
- w  output  1  west pulse
- busy  output  1  high in DRIVE/GAP
- done  output  1  high in DONE
- result  output  2  00=none, 01=won, 10=dead, 11=exhausted; valid while done
- moves_made  output  $clog2(DEPTH+1)  moves issued in current/last run
- overflow  output  1  sticky; a load was dropped because the script was full

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, script count=0, idx=0.
  - All outputs 0 (n,s,e,w,busy,done,result,moves_made,overflow).
  - Reset wins over every other input, in every state.
- Script storage: DEPTH x 2-bit register array plus count.
  - Load when count==DEPTH: dropped, overflow<=1.
  - Load in DRIVE/GAP: ignored, no overflow.
  - clear: count<=0, overflow<=0. If clear and load_en are high in the same cycle, clear wins.
- FSM states: IDLE, DRIVE, GAP, DONE.
- IDLE:
  - start && count!=0 -> DRIVE, idx<=0, moves_made<=0.
  - start && count==0 -> DONE, result=11 (exhausted).
- DRIVE (exactly 1 cycle):
  - Drive the one-hot output decoded from script[idx]; the other three outputs are 0.
  - idx<=idx+1, moves_made<=moves_made+1, gap counter<=0 -> GAP.
  - n/s/e/w are registered: the pulse is high for exactly one clk cycle and never two outputs at once.
- GAP (GAP cycles): all direction outputs 0.
  - After GAP cycles: if idx==count -> DONE, result=11; else -> DRIVE.
- Terminal sampling, in DRIVE and GAP:
  - d==1 -> DONE, result=10. win==1 -> DONE, result=01.
  - d and win both high: dead (10) takes priority.
  - A terminal event on the cycle the script exhausts takes priority over exhausted.
  - The direction pulse already in flight in DRIVE is still output that cycle; the next state is DONE.
- DONE:
  - done=1, busy=0; result and moves_made hold.
  - start (count!=0) -> DRIVE from idx 0, result<=00, done<=0. The script is kept.
  - d/win are ignored in IDLE and DONE.
- start while busy: ignored.
- Reset mid-run: the next cycle has all outputs 0 and state IDLE, and the script is lost.

Decomposition:
- Shared package game_pkg:
  - Typedef dir_code_t (2-bit, values DIR_N/DIR_S/DIR_E/DIR_W).
  - Typedef result_t (RES_NONE/RES_WON/RES_DEAD/RES_EXHAUSTED).
  - Typedef player_state_t.
- One natural sub-module, dir_decode: combinational dir_code_t -> 4-bit one-hot {n,s,e,w}. The game bench can reuse it.
- Storage and FSM stay in move_player.

Test Plan:
- Load E,S,W,E; start; d/win held 0 (GAP=2).
  - Required: e, s, w, e pulses on cycles 1, 4, 7, 10 after start, one cycle each.
  - Required: done=1, result=11, moves_made=4 three cycles after the last pulse.
- Same script; bench raises win 1 cycle after the 3rd pulse.
  - Required: next state DONE, result=01, moves_made=3, no 4th pulse.
- d and win raised in the same cycle during GAP.
  - Required: result=10 (dead).
- Load 17 moves with DEPTH=16.
  - Required: overflow=1, count=16, replay issues 16 pulses.
  - Then clear: overflow=0, and start gives result=11 with moves_made=0.
- Pull reset low during DRIVE.
  - Required: the next cycle has n=s=e=w=0, busy=0, done=0, state IDLE.
  - A following start with an empty script gives result=11.
- Loads and start while busy: ignored. After DONE, start replays the identical pulse sequence.
